uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Downstream consumer of the APB UART interface's transmit path: holds the TX FIFO
//  written by tx_fifo_writeEn/tx_fifo_dataIn and drains it onto the serial line.
//  Each byte is sent as an 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit.
//  Exports Full/Empty back to the APB interface for PREADY generation.
// PARAMETERS
//  DEPTH         16   FIFO entries; must be a power of two.
//  ADDR_W        4    log2(DEPTH); pointer width.
//  CLKS_PER_BIT  868  PCLK cycles per serial bit, >=2 (100 MHz / 115200).
// PORTS
//  PCLK             in   1  clock.
//  PRESETn          in   1  reset, asynchronous, active-high.
//  tx_fifo_writeEn  in   1  push strobe; one byte per cycle in which it is high.
//  tx_fifo_dataIn   in   8  byte to push.
//  tx_fifo_Full     out  1  count == DEPTH (combinational from count).
//  tx_fifo_Empty    out  1  count == 0 (combinational from count).
//  tx_overflow      out  1  1-cycle pulse: push dropped because FIFO full.
//  tx_busy          out  1  FSM is not in IDLE.
//  tx               out  1  serial line; idle high.
// BEHAVIOUR
//  Reset (PRESETn=1, async): wr_ptr=rd_ptr=0, count=0, FSM=IDLE, tx=1, tx_busy=0,
//   tx_overflow=0, baud_cnt=0, bit_idx=0, shift=0; Empty=1, Full=0. Storage not cleared.
//   Reset mid-frame aborts the frame; tx returns high immediately; FIFO contents lost.
//  FIFO: count is ADDR_W+1 bits wide; pointers wrap modulo DEPTH.
//   - push when writeEn && count<DEPTH: mem[wr_ptr]<=dataIn, wr_ptr++.
//   - push when writeEn && count==DEPTH: dropped, tx_overflow=1 next cycle. A same-cycle
//     pop does NOT rescue it (full is evaluated before the pop).
//   - pop occurs only in IDLE when count>0: shift<=mem[rd_ptr], rd_ptr++.
//   - push+pop in the same cycle: count unchanged, both pointers advance.
//   - push into an empty FIFO: Empty drops the next cycle; pop no earlier than the cycle
//     after that (no write-through).
//  FSM states: IDLE, START, DATA, STOP.
//   - IDLE: tx=1. If !Empty: pop, baud_cnt=0, go to START.
//   - START: tx=0 for CLKS_PER_BIT cycles, then bit_idx=0 and go to DATA.
//   - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. At each bit end: shift>>=1 and
//     bit_idx++. After bit_idx==7 completes, go to STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if !Empty, pop and go straight to START
//     (back-to-back frames, no extra idle bit); else go to IDLE.
//   - baud_cnt counts 0..CLKS_PER_BIT-1 and clears on every state/bit change.
//  Timing:
//   - tx is registered.
//   - Start bit begins the cycle after the pop; the pop occurs the cycle after Empty
//     falls.
//   - Frame length is exactly 10*CLKS_PER_BIT cycles.
//  tx_busy=1 in START/DATA/STOP. The byte being sent is already out of the FIFO, so
//  Full can deassert while tx_busy=1.
// TESTING
//  T1 CLKS_PER_BIT=4: push 0xA5 -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles
//     each), then high 4 cycles; Empty=1 and tx_busy=0 after 40 cycles.
//  T2 push 0x00,0xFF back-to-back -> two frames, 80 contiguous cycles; the second start
//     bit immediately follows the first stop bit.
//  T3 push 17 bytes while the FSM is stalled mid-frame (DEPTH=16):
//     - Full=1 after the 16th push;
//     - the 17th push raises tx_overflow for 1 cycle;
//     - the dropped byte is never transmitted.
//  T4 with count==DEPTH, push in the same cycle as the STOP->START pop -> push dropped,
//     tx_overflow=1, count=DEPTH-1.
//  T5 assert PRESETn during DATA bit 3 -> tx=1 and Empty=1 immediately; after release, a
//     new push 0x3C yields a clean, complete frame.
//  T6 fill to 16, drain fully -> pointer wrap is correct; bytes leave in push order
//     (scoreboard compare).

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Transmit side of the APB UART: a DEPTH-entry byte FIFO fed by the APB
// interface, drained by an 8N1 serializer. Each frame has one start bit
// (low), eight data bits sent LSB first, and one stop bit (high). A frame
// lasts exactly 10*CLKS_PER_BIT cycles. When more bytes are waiting, frames
// follow each other with no idle gap.
//
// Push handshake: tx_fifo_writeEn is the valid and !tx_fifo_Full is the
// ready. A byte is taken on every rising PCLK edge where both are high.
// If tx_fifo_writeEn is high while Full, the byte is dropped and
// tx_overflow pulses for one cycle. Full is judged before any pop in the
// same cycle, so a simultaneous pop does not rescue the byte.
module uart_tx_serializer #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       tx_fifo_writeEn,
  input  logic [7:0] tx_fifo_dataIn,
  output logic       tx_fifo_Full,
  output logic       tx_fifo_Empty,
  output logic       tx_overflow,
  output logic       tx_busy,
  output logic       tx,
  output logic [1:0] dbg_state
);

  localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]        mem [DEPTH];

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q,  bit_idx_d;
  logic [7:0]        shift_q,    shift_d;
  logic              tx_q,       tx_d;
  logic              ovf_q,      ovf_d;

  logic              push;
  logic              pop;
  logic              baud_done;

  assign tx_fifo_Full  = (count_q == COUNT_FULL);
  assign tx_fifo_Empty = (count_q == '0);
  assign push          = tx_fifo_writeEn && !tx_fifo_Full;
  assign baud_done     = (baud_cnt_q == BAUD_LAST);

  assign tx          = tx_q;
  assign tx_overflow = ovf_q;
  assign tx_busy     = (state_q != S_IDLE);
  assign dbg_state   = state_q;

  // Serializer next state: bit timing, frame sequencing and FIFO pops.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        if (!tx_fifo_Empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          // A waiting byte starts its frame right after this stop bit.
          if (!tx_fifo_Empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping, overflow flag and the registered line level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = tx_fifo_writeEn && tx_fifo_Full;
    // The line level follows the next state, so the start bit appears
    // on the cycle right after the pop.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // All control state. Reset aborts any frame and empties the FIFO.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO storage; its contents are not cleared by reset.
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem[wr_ptr_q] <= tx_fifo_dataIn;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer with CLKS_PER_BIT=4 and DEPTH=16.
// A queue model predicts every output on every cycle. It describes each
// frame as 10 bit slots of CPB cycles. A line receiver decodes tx and checks
// the received bytes against exp_q. Directed sections pin literal waveforms.
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       PCLK;
  logic       PRESETn;
  logic       tx_fifo_writeEn;
  logic [7:0] tx_fifo_dataIn;
  logic       tx_fifo_Full;
  logic       tx_fifo_Empty;
  logic       tx_overflow;
  logic       tx_busy;
  logic       tx;
  logic [1:0] dbg_state;

  uart_tx_serializer #(
    .DEPTH(DEPTH),
    .ADDR_W(4),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .tx_fifo_writeEn(tx_fifo_writeEn),
    .tx_fifo_dataIn(tx_fifo_dataIn),
    .tx_fifo_Full(tx_fifo_Full),
    .tx_fifo_Empty(tx_fifo_Empty),
    .tx_overflow(tx_overflow),
    .tx_busy(tx_busy),
    .tx(tx),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];    // bytes waiting in the FIFO
  logic [7:0] exp_q[$];  // accepted bytes not yet seen on the line
  bit         m_active;
  int         m_fc;      // cycle index inside the current frame
  logic [7:0] m_cur;
  bit         m_ovf;

  function automatic logic frame_bit(input logic [7:0] b, input int fc);
    int k;
    k = fc / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  always @(posedge PCLK or posedge PRESETn) begin
    int  sz;
    bit  do_push;
    bit  do_pop;
    if (PRESETn) begin
      m_q.delete();
      exp_q.delete();
      m_active = 1'b0;
      m_fc     = 0;
      m_ovf    = 1'b0;
    end else begin
      sz      = m_q.size();
      do_push = tx_fifo_writeEn && (sz < DEPTH);
      m_ovf   = tx_fifo_writeEn && (sz == DEPTH);
      do_pop  = (sz > 0) && (!m_active || m_fc == FRAME - 1);
      if (do_pop) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_fc     = 0;
      end else if (m_active) begin
        if (m_fc == FRAME - 1) m_active = 1'b0;
        else m_fc++;
      end
      if (do_push) begin
        m_q.push_back(tx_fifo_dataIn);
        exp_q.push_back(tx_fifo_dataIn);
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge PCLK) begin
    if (chk_en) begin
      check("cyc_tx",    tx,            m_active ? frame_bit(m_cur, m_fc) : 1'b1);
      check("cyc_busy",  tx_busy,       m_active);
      check("cyc_empty", tx_fifo_Empty, m_q.size() == 0);
      check("cyc_full",  tx_fifo_Full,  m_q.size() == DEPTH);
      check("cyc_ovf",   tx_overflow,   m_ovf);
    end
  end

  // ---------------- line receiver / scoreboard ----------------
  bit         rx_busy = 1'b0;
  int         rx_cnt  = 0;
  logic [7:0] rx_byte;
  logic [7:0] rx_exp;

  always @(negedge PCLK) begin
    if (PRESETn) begin
      rx_busy = 1'b0;
      rx_cnt  = 0;
    end else if (!rx_busy) begin
      if (chk_en && tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2) begin
        rx_byte[rx_cnt / CPB - 1] = tx;
      end else if (rx_cnt == 9 * CPB + CPB / 2) begin
        check("rx_stop", tx, 1);
        check("rx_have_exp", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          rx_exp = exp_q.pop_front();
          check("rx_byte", rx_byte, rx_exp);
        end
        rx_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    @(posedge PCLK); #1;
    tx_fifo_writeEn = 1'b1;
    tx_fifo_dataIn  = b;
    @(posedge PCLK); #1;
    tx_fifo_writeEn = 1'b0;
  endtask

  task automatic wait_model_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(m_q.size() == 0 && !m_active) && n < budget) begin
      @(posedge PCLK); #1;
      n++;
    end
    check({name, "_in_time"}, n < budget, 1);
    @(posedge PCLK); #1;
    check({name, "_idle"}, tx_fifo_Empty && !tx_busy && tx, 1);
  endtask

  task automatic wait_model_fc(input int fc, input int budget, input string name);
    int n;
    n = 0;
    while (!(m_active && m_fc == fc) && n < budget) begin
      @(posedge PCLK); #1;
      n++;
    end
    check(name, n < budget, 1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [9:0]  t1_bits;
  logic [19:0] t2_bits;
  logic [9:0]  t5_bits;

  initial begin
    t1_bits = 10'b1_10100101_0;                    // 0xA5
    t2_bits = {10'b1_11111111_0, 10'b1_00000000_0}; // 0x00 then 0xFF
    t5_bits = 10'b1_00111100_0;                    // 0x3C

    PRESETn         = 1'b1;
    tx_fifo_writeEn = 1'b0;
    tx_fifo_dataIn  = 8'h00;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_tx",    tx,            1);
    check("rst_empty", tx_fifo_Empty, 1);
    check("rst_full",  tx_fifo_Full,  0);
    check("rst_busy",  tx_busy,       0);
    check("rst_ovf",   tx_overflow,   0);
    check("rst_state", dbg_state,     0);
    PRESETn = 1'b0;
    chk_en  = 1'b1;
    repeat (2) @(posedge PCLK);

    // T1: single 0xA5 frame.
    push_byte(8'hA5);
    check("t1_empty_drop", tx_fifo_Empty, 0);
    @(posedge PCLK); #1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge PCLK);
      check("t1_tx", tx, t1_bits[i / CPB]);
    end
    @(posedge PCLK); #1;
    check("t1_end_empty", tx_fifo_Empty, 1);
    check("t1_end_busy",  tx_busy,       0);

    // T2: back-to-back 0x00, 0xFF; 80 contiguous cycles.
    @(posedge PCLK); #1;
    tx_fifo_writeEn = 1'b1;
    tx_fifo_dataIn  = 8'h00;
    @(posedge PCLK); #1;
    tx_fifo_dataIn  = 8'hFF;
    @(posedge PCLK); #1;
    tx_fifo_writeEn = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge PCLK);
      check("t2_tx", tx, t2_bits[i / CPB]);
    end
    @(posedge PCLK); #1;
    check("t2_end_busy", tx_busy, 0);

    // T5: reset during data bit 3, then a clean 0x3C frame.
    push_byte(8'h5A);
    wait_model_fc(4 * CPB + 1, 100, "t5_reach_bit3");
    #2;
    PRESETn = 1'b1;
    #1;
    check("t5_rst_tx",    tx,            1);
    check("t5_rst_empty", tx_fifo_Empty, 1);
    check("t5_rst_busy",  tx_busy,       0);
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    push_byte(8'h3C);
    @(posedge PCLK); #1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge PCLK);
      check("t5_tx", tx, t5_bits[i / CPB]);
    end
    @(posedge PCLK); #1;
    check("t5_end_busy", tx_busy, 0);

    // T3: 17 pushes while a frame is in flight.
    push_byte(8'h11);
    repeat (3) @(posedge PCLK);
    #1;
    for (int k = 0; k < 17; k++) begin
      tx_fifo_writeEn = 1'b1;
      tx_fifo_dataIn  = 8'h40 + 8'(k);
      @(posedge PCLK); #1;
      if (k == 14) check("t3_not_full_15", tx_fifo_Full, 0);
      if (k == 15) check("t3_full_16",     tx_fifo_Full, 1);
      if (k == 16) check("t3_ovf_17",      tx_overflow,  1);
    end
    tx_fifo_writeEn = 1'b0;
    @(posedge PCLK); #1;
    check("t3_ovf_pulse_end", tx_overflow,  0);
    check("t3_still_full",    tx_fifo_Full, 1);

    // T4: push on the STOP->START pop edge with the FIFO full.
    wait_model_fc(FRAME - 1, 200, "t4_reach_stop_end");
    tx_fifo_writeEn = 1'b1;
    tx_fifo_dataIn  = 8'hEE;
    @(posedge PCLK); #1;
    tx_fifo_writeEn = 1'b0;
    check("t4_ovf",   tx_overflow,   1);
    check("t4_full",  tx_fifo_Full,  0);
    check("t4_empty", tx_fifo_Empty, 0);
    check("t4_busy",  tx_busy,       1);
    wait_model_idle(20 * FRAME, "t4_drain");

    // T6: fill to 16 and drain fully; pointers have wrapped by now.
    @(posedge PCLK); #1;
    for (int k = 0; k < 17; k++) begin
      tx_fifo_writeEn = 1'b1;
      tx_fifo_dataIn  = 8'(k * 29 + 3);
      @(posedge PCLK); #1;
    end
    tx_fifo_writeEn = 1'b0;
    check("t6_full", tx_fifo_Full, 1);
    wait_model_idle(20 * FRAME, "t6_drain");

    repeat (2 * CPB) @(posedge PCLK);
    #1;
    check("end_expq_empty", exp_q.size(), 0);
    check("end_rx_idle",    rx_busy,      0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
